// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared IEEE-754 single-precision helpers for the FP datapath blocks.
//   - constants: bias, +Inf, canonical quiet NaN, maximum biased exponent
//   - fp_unpacked_t: sign / biased exponent / 24-bit significand (hidden bit)
//   - fp_unpack, fp_is_nan, fp_is_inf helpers
//   - acc_state_e: accumulator FSM state encoding
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int unsigned FP_BIAS    = 127;
   localparam logic [31:0] FP_INF     = 32'h7F80_0000;
   localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
   localparam int unsigned FP_EXP_MAX = 255;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [23:0] man;
   } fp_unpacked_t;

   typedef enum logic [1:0] {
      StIdle,
      StAlign,
      StAdd,
      StNorm
   } acc_state_e;

   // Exponent 0 is flushed to zero: denormal fractions are discarded.
   function automatic fp_unpacked_t fp_unpack(input logic [31:0] f);
      fp_unpacked_t u;
      u.sign = f[31];
      u.exp  = f[30:23];
      u.man  = (f[30:23] == 8'd0) ? 24'd0 : {1'b1, f[22:0]};
      return u;
   endfunction

   function automatic logic fp_is_nan(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
   endfunction

   function automatic logic fp_is_inf(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
   endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// -----------------------------------------------------------------------------
// fp_sync_fifo
// Single-clock FIFO for FP operands. DEPTH must be a power of two (>= 2).
// A push into a full FIFO is accepted only when a pop happens at the same edge.
// i_clear empties the FIFO; a push at the same edge lands in the empty FIFO.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   i_clear            synchronous flush
//   i_push, i_wdata    write strobe and data
//   i_pop              read strobe (ignored when empty or clearing)
//   o_rdata            head entry
//   o_full, o_empty    status
//   o_count            number of stored entries
// -----------------------------------------------------------------------------
module fp_sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   i_clear,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;

   logic             w_pop_ok;
   logic             w_push_ok;
   logic             w_wr_en;
   logic [AW-1:0]    w_wr_addr;

   assign w_pop_ok  = i_pop && (r_count != '0);
   assign w_push_ok = i_push && ((r_count != FULL_CNT) || w_pop_ok);

   // A clear rewinds both pointers, so a simultaneous push goes to slot 0.
   assign w_wr_en   = i_clear ? i_push : w_push_ok;
   assign w_wr_addr = i_clear ? '0 : r_wptr;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_wr_addr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_rptr  <= '0;
         r_wptr  <= AW'(i_push);
         r_count <= (AW + 1)'(i_push);
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= r_count + (AW + 1)'(w_push_ok) - (AW + 1)'(w_pop_ok);
      end
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/float_point_accumulate.sv
// -----------------------------------------------------------------------------
// float_point_accumulate
// Accumulates IEEE-754 single-precision products into a running sum.
// Products are queued in a FIFO and added by a fixed 4-cycle FSM
// (IDLE -> ALIGN -> ADD -> NORM). Truncating rounding, flush-to-zero.
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   iValid, iZ     product strobe and value (from the multiplier)
//   iClear         synchronous clear of sum, FIFO, in-flight add, overflow
//   oSum           running sum
//   oDone          one-cycle pulse after each oSum update
//   oBusy          FIFO non-empty or FSM active (registered)
//   oOverflow      sticky: a product was dropped on a full FIFO
// -----------------------------------------------------------------------------
module float_point_accumulate
   import fp_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iValid,
   input  logic [31:0] iZ,
   input  logic        iClear,
   output logic [31:0] oSum,
   output logic        oDone,
   output logic        oBusy,
   output logic        oOverflow
);

   localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam logic signed [9:0] EXP_MAX_S = 10'(FP_EXP_MAX);

   // FIFO interface
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [31:0]      w_fifo_rdata;
   logic [CNT_W-1:0] w_fifo_count;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_pop;
   logic             w_push_ok;
   logic             w_drop;
   logic             w_busy_next;

   // FSM and output state
   acc_state_e       r_state;
   logic [31:0]      r_sum;
   logic             r_done;
   logic             r_busy;
   logic             r_ovf;
   logic [31:0]      r_b;

   // ALIGN results
   logic             r_special;
   logic [31:0]      r_special_val;
   logic             r_big_sign;
   logic             r_small_sign;
   logic [7:0]       r_big_exp;
   logic [23:0]      r_big_man;
   logic [23:0]      r_small_man;

   // ADD results
   logic [24:0]      r_mag;
   logic             r_res_sign;

   // ALIGN combinational
   fp_unpacked_t     w_a;
   fp_unpacked_t     w_b;
   fp_unpacked_t     w_big;
   fp_unpacked_t     w_small;
   logic [7:0]       w_diff;
   logic [23:0]      w_small_sh;
   logic             w_special;
   logic [31:0]      w_special_val;

   // ADD combinational
   logic [24:0]      w_mag;
   logic             w_res_sign;

   // NORM combinational
   logic [4:0]       w_lzc;
   logic signed [9:0] w_exp_norm;
   logic [22:0]      w_frac;
   logic [31:0]      w_norm_result;

   fp_sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_clear (iClear),
      .i_push  (iValid),
      .i_wdata (iZ),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign w_pop     = (r_state == StIdle) && !w_fifo_empty && !iClear;
   assign w_push_ok = iValid && (!w_fifo_full || w_pop);
   assign w_drop    = iValid && w_fifo_full && !w_pop && !iClear;

   // Next FIFO occupancy, mirrored here so oBusy can be registered.
   always_comb begin
      if (iClear) begin
         w_cnt_next = CNT_W'(iValid);
      end else begin
         w_cnt_next = w_fifo_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
      end
   end

   assign w_busy_next = (w_cnt_next != '0) ||
                        (!iClear && ((r_state == StAlign) || (r_state == StAdd) || w_pop));

   // ALIGN: specials, exponent compare/swap, significand shift.
   always_comb begin
      w_a           = fp_unpack(r_sum);
      w_b           = fp_unpack(r_b);
      w_special     = 1'b1;
      w_special_val = FP_QNAN;
      if (fp_is_nan(r_sum) || fp_is_nan(r_b)) begin
         w_special_val = FP_QNAN;
      end else if (fp_is_inf(r_sum) && fp_is_inf(r_b) && (w_a.sign != w_b.sign)) begin
         w_special_val = FP_QNAN;
      end else if (fp_is_inf(r_sum)) begin
         w_special_val = {w_a.sign, FP_INF[30:0]};
      end else if (fp_is_inf(r_b)) begin
         w_special_val = {w_b.sign, FP_INF[30:0]};
      end else begin
         w_special = 1'b0;
      end

      if (w_b.exp > w_a.exp) begin
         w_big   = w_b;
         w_small = w_a;
      end else begin
         w_big   = w_a;
         w_small = w_b;
      end
      w_diff     = w_big.exp - w_small.exp;
      w_small_sh = (w_diff >= 8'd25) ? 24'd0 : (w_small.man >> w_diff);
   end

   // ADD: magnitude add/subtract, sign follows the larger magnitude.
   always_comb begin
      if (r_big_sign == r_small_sign) begin
         w_mag      = {1'b0, r_big_man} + {1'b0, r_small_man};
         w_res_sign = r_big_sign;
      end else if (r_big_man >= r_small_man) begin
         w_mag      = {1'b0, r_big_man - r_small_man};
         w_res_sign = r_big_sign;
      end else begin
         w_mag      = {1'b0, r_small_man - r_big_man};
         w_res_sign = r_small_sign;
      end
   end

   // NORM: leading-zero count over the 24-bit field.
   always_comb begin
      logic v_found;
      v_found = 1'b0;
      w_lzc   = 5'd0;
      for (int i = 23; i >= 0; i--) begin
         if (!v_found && r_mag[i]) begin
            w_lzc   = 5'(23 - i);
            v_found = 1'b1;
         end
      end
   end

   // Only bits [22:0] of the left-shifted significand survive packing, so the
   // shift can be done on r_mag[22:0] directly.
   always_comb begin
      if (r_mag[24]) begin
         w_frac     = r_mag[23:1];
         w_exp_norm = 10'({2'b00, r_big_exp}) + 10'sd1;
      end else begin
         w_frac     = r_mag[22:0] << w_lzc;
         w_exp_norm = 10'({2'b00, r_big_exp}) - 10'({5'b00000, w_lzc});
      end

      if (r_mag == 25'd0) begin
         w_norm_result = 32'h0000_0000;
      end else if (w_exp_norm <= 10'sd0) begin
         w_norm_result = 32'h0000_0000;
      end else if (w_exp_norm >= EXP_MAX_S) begin
         w_norm_result = {r_res_sign, FP_INF[30:0]};
      end else begin
         w_norm_result = {r_res_sign, w_exp_norm[7:0], w_frac};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= StIdle;
         r_sum         <= 32'h0000_0000;
         r_done        <= 1'b0;
         r_busy        <= 1'b0;
         r_ovf         <= 1'b0;
         r_b           <= 32'h0000_0000;
         r_special     <= 1'b0;
         r_special_val <= 32'h0000_0000;
         r_big_sign    <= 1'b0;
         r_small_sign  <= 1'b0;
         r_big_exp     <= 8'd0;
         r_big_man     <= 24'd0;
         r_small_man   <= 24'd0;
         r_mag         <= 25'd0;
         r_res_sign    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_busy <= w_busy_next;
         if (iClear) begin
            // Abandons any in-flight add without a done pulse.
            r_state <= StIdle;
            r_sum   <= 32'h0000_0000;
            r_ovf   <= 1'b0;
         end else begin
            if (w_drop) begin
               r_ovf <= 1'b1;
            end
            unique case (r_state)
               StIdle: begin
                  if (w_pop) begin
                     r_b     <= w_fifo_rdata;
                     r_state <= StAlign;
                  end
               end
               StAlign: begin
                  r_special     <= w_special;
                  r_special_val <= w_special_val;
                  r_big_sign    <= w_big.sign;
                  r_small_sign  <= w_small.sign;
                  r_big_exp     <= w_big.exp;
                  r_big_man     <= w_big.man;
                  r_small_man   <= w_small_sh;
                  r_state       <= StAdd;
               end
               StAdd: begin
                  r_mag      <= w_mag;
                  r_res_sign <= w_res_sign;
                  r_state    <= StNorm;
               end
               StNorm: begin
                  r_sum   <= r_special ? r_special_val : w_norm_result;
                  r_done  <= 1'b1;
                  r_state <= StIdle;
               end
            endcase
         end
      end
   end

   assign oSum      = r_sum;
   assign oDone     = r_done;
   assign oBusy     = r_busy;
   assign oOverflow = r_ovf;

endmodule

// File: tb/tb_float_point_accumulate.sv
// -----------------------------------------------------------------------------
// tb_float_point_accumulate
// Directed self-checking bench for float_point_accumulate (FIFO_DEPTH = 4).
// -----------------------------------------------------------------------------
module tb_float_point_accumulate;

   logic        clk = 1'b0;
   logic        resetn;
   logic        iValid;
   logic [31:0] iZ;
   logic        iClear;
   logic [31:0] oSum;
   logic        oDone;
   logic        oBusy;
   logic        oOverflow;

   int checks   = 0;
   int failures = 0;

   int n_edge         = 0;
   int done_cnt       = 0;
   int last_done_edge = -100;

   int base;
   int e0;

   float_point_accumulate #(
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .iValid    (iValid),
      .iZ        (iZ),
      .iClear    (iClear),
      .oSum      (oSum),
      .oDone     (oDone),
      .oBusy     (oBusy),
      .oOverflow (oOverflow)
   );

   always #5 clk = ~clk;

   // oDone read here is the value from the cycle after the previous edge.
   always @(posedge clk) begin
      n_edge++;
      if (oDone === 1'b1) begin
         done_cnt++;
         last_done_edge = n_edge - 1;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp_v);
      end
   endtask

   // Present inputs for exactly one rising edge, then return 1 time unit after it.
   task automatic drive(input logic v, input logic [31:0] z, input logic c);
      iValid = v;
      iZ     = z;
      iClear = c;
      @(posedge clk);
      #1;
      iValid = 1'b0;
      iClear = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_dones(input int target, input int budget, input string tag);
      int k = 0;
      while (done_cnt < target && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check(tag, done_cnt, target);
   endtask

   initial begin
      resetn = 1'b0;
      iValid = 1'b0;
      iClear = 1'b0;
      iZ     = 32'h0;
      idle(3);
      check("rst_sum", oSum, 32'h0000_0000);
      check("rst_done", {31'd0, oDone}, 32'd0);
      check("rst_busy", {31'd0, oBusy}, 32'd0);
      check("rst_ovf", {31'd0, oOverflow}, 32'd0);
      resetn = 1'b1;
      idle(2);

      // 106.25 + (-425) = -318.75
      base = done_cnt;
      drive(1'b1, 32'h42D4_8000, 1'b0);
      e0 = n_edge;
      check("a_busy_high", {31'd0, oBusy}, 32'd1);
      drive(1'b1, 32'hC3D4_8000, 1'b0);
      wait_dones(base + 1, 20, "a_first_done");
      check("a_latency", last_done_edge - e0, 32'd4);
      wait_dones(base + 2, 20, "a_second_done");
      idle(6);
      check("a_done_count", done_cnt - base, 32'd2);
      check("a_sum", oSum, 32'hC39F_6000);
      check("a_busy_low", {31'd0, oBusy}, 32'd0);

      // Exact cancellation gives +0
      drive(1'b0, 32'h0, 1'b1);
      check("b_clear_sum", oSum, 32'h0000_0000);
      base = done_cnt;
      drive(1'b1, 32'h42D4_8000, 1'b0);
      drive(1'b1, 32'hC2D4_8000, 1'b0);
      wait_dones(base + 2, 30, "b_dones");
      check("b_sum", oSum, 32'h0000_0000);

      // Overflow to Inf, then NaN handling
      drive(1'b0, 32'h0, 1'b1);
      base = done_cnt;
      drive(1'b1, 32'h7F7F_FFFF, 1'b0);
      drive(1'b1, 32'h7F7F_FFFF, 1'b0);
      wait_dones(base + 2, 30, "c_dones_inf");
      check("c_sum_inf", oSum, 32'h7F80_0000);
      drive(1'b1, 32'h7FC0_0001, 1'b0);
      wait_dones(base + 3, 20, "c_done_nan");
      check("c_sum_nan", oSum, 32'h7FC0_0000);
      drive(1'b1, 32'h3F80_0000, 1'b0);
      wait_dones(base + 4, 20, "c_done_nan_sticky");
      check("c_sum_nan_sticky", oSum, 32'h7FC0_0000);

      // 8 back-to-back 1.0: 6 accepted, 7th onwards dropped
      drive(1'b0, 32'h0, 1'b1);
      base = done_cnt;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 32'h3F80_0000, 1'b0);
         if (i == 5) check("d_ovf_before_7th", {31'd0, oOverflow}, 32'd0);
         if (i == 6) check("d_ovf_at_7th", {31'd0, oOverflow}, 32'd1);
      end
      wait_dones(base + 6, 40, "d_dones");
      idle(10);
      check("d_done_count", done_cnt - base, 32'd6);
      check("d_sum", oSum, 32'h40C0_0000);
      check("d_ovf_sticky", {31'd0, oOverflow}, 32'd1);
      check("d_busy_low", {31'd0, oBusy}, 32'd0);

      // iClear during ADD with 2 queued and a simultaneous 2.0 product
      drive(1'b0, 32'h0, 1'b1);
      check("e_clear_ovf", {31'd0, oOverflow}, 32'd0);
      base = done_cnt;
      drive(1'b1, 32'h3F80_0000, 1'b0);
      drive(1'b1, 32'h3F80_0000, 1'b0);
      drive(1'b1, 32'h3F80_0000, 1'b0);
      drive(1'b1, 32'h4000_0000, 1'b1);
      e0 = n_edge;
      wait_dones(base + 1, 20, "e_done");
      check("e_latency", last_done_edge - e0, 32'd4);
      idle(8);
      check("e_done_count", done_cnt - base, 32'd1);
      check("e_sum", oSum, 32'h4000_0000);
      check("e_ovf", {31'd0, oOverflow}, 32'd0);

      // Asynchronous reset mid-operation
      base = done_cnt;
      drive(1'b1, 32'h3F80_0000, 1'b0);
      idle(1);
      resetn = 1'b0;
      #1;
      check("f_rst_sum", oSum, 32'h0000_0000);
      check("f_rst_busy", {31'd0, oBusy}, 32'd0);
      idle(2);
      resetn = 1'b1;
      idle(8);
      check("f_no_done", done_cnt - base, 32'd0);
      check("f_sum", oSum, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/float_point_accumulate.md
# float_point_accumulate

Downstream consumer of `float_point_multiply`: captures each product on `oDone`/`oZ` and adds it into a running IEEE-754 single-precision sum, giving a multiply-accumulate path. The multiplier has no back-pressure, so products land in a small input FIFO that is drained by a 4-state add FSM. The running sum is always visible on `oSum`, and `oDone` pulses once per completed add.

## Interface
- `FIFO_DEPTH`, default 4: product FIFO entries; must be a power of 2 and at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `iValid` in 1: product strobe; wire it to the multiplier `oDone`.
- `iZ` in 32: product, IEEE-754 single; wire it to the multiplier `oZ`.
- `iClear` in 1: synchronous clear of the sum, the FIFO, the in-flight add and `oOverflow`.
- `oSum` out 32: running sum. Reset value 0x00000000.
- `oDone` out 1: one-cycle pulse when `oSum` has just been updated. Reset value 0.
- `oBusy` out 1: high when the FIFO is non-empty or the FSM is not in IDLE. Reset value 0.
- `oOverflow` out 1: sticky flag, set when a product is dropped because the FIFO is full. Reset value 0.

## Operation
- **FIFO write:** `iValid` high at an edge writes `iZ`.
  - If the FIFO is full and no pop happens at that edge, the product is dropped and `oOverflow` is set.
  - If the FIFO is full and a pop happens at the same edge, the write is accepted.
- **FSM:**
  - IDLE: FIFO non-empty → pop → ALIGN.
  - ALIGN: unpack the popped operand B and the accumulator A, then resolve specials. If B's exponent is larger, swap so A holds the larger exponent. Right-shift the smaller 24-bit significand (hidden bit included) by the exponent difference; a difference of 25 or more shifts it to 0. → ADD.
  - ADD: equal signs add, unequal signs subtract smaller from larger; 25-bit magnitude result; result sign is the sign of the larger magnitude. → NORM.
  - NORM: a carry shifts right by 1 and increments the exponent. Otherwise shift left by the leading-zero count and decrement the exponent. Truncate (round toward zero), pack, write `oSum`, pulse `oDone`. → IDLE.
- **Special cases:**
  - Input exponent 0 is treated as ±0 (flush-to-zero).
  - Zero magnitude result gives +0 (0x00000000).
  - Result exponent ≤ 0 flushes to +0.
  - Result exponent ≥ 255 gives ±Inf (0x7F800000 / 0xFF800000).
  - Any NaN operand, or Inf plus opposite-signed Inf, gives canonical NaN 0x7FC00000.
  - Otherwise Inf plus a finite value gives that Inf.
  - Special results skip ADD/NORM arithmetic but still take the same 4 cycles, keeping latency fixed.
- **iClear:** has priority over everything except reset.
  - Sum → 0, FIFO emptied, FSM → IDLE with no `oDone`, `oOverflow` → 0.
  - An `iValid` at the same edge is written into the now-empty FIFO.
- **Reset mid-operation:** all state returns to reset values; in-flight and queued products are lost.

## Timing
- Product sampled at edge E0 with the FSM idle and the FIFO empty:
  - pop at E1 (→ ALIGN), ADD at E2, NORM at E3;
  - `oSum` updated at E4, `oDone` high for the cycle after E4.
- Latency from sample to `oSum` update: 4 edges.
- Throughput: one add per 4 cycles; IDLE pops again at E5 if data is waiting.
- Back-to-back input: depth 4 absorbs 6 consecutive products; the 7th and later are dropped while ADD/NORM are busy.
- `oBusy` is registered and falls in the cycle after the last NORM when the FIFO is empty.

## Structure
- Shared package `fp_pkg` holds:
  - constants `FP_BIAS=127`, `FP_INF=32'h7F800000`, `FP_QNAN=32'h7FC00000`, `FP_EXP_MAX=255`;
  - the unpacked struct (sign, exp[7:0], man[23:0]);
  - functions `fp_unpack` and `fp_is_nan`.
- Sub-module `fp_sync_fifo` (parameterised width and depth, with full, empty, push, pop and clear) is reused for any future FP queue.
- The FSM, alignment, add and normalise logic stay in `float_point_accumulate`.

## Test plan
- Reset with `resetn` low: `oSum`=0x00000000, `oDone`=0, `oBusy`=0, `oOverflow`=0.
- 0x42D48000 (106.25), then 0xC3D48000 (−425), one cycle apart → `oDone` twice; final `oSum`=0xC39F6000 (−318.75); first `oDone` exactly 4 edges after the first sample.
- 0x42D48000 then 0xC2D48000 → `oSum`=0x00000000 (exact cancellation gives +0).
- 0x7F7FFFFF twice → `oSum`=0x7F800000; then 0x7FC00001 → 0x7FC00000; a following 0x3F800000 leaves 0x7FC00000.
- 8 back-to-back 0x3F800000 with `FIFO_DEPTH`=4 → `oOverflow`=1 from the 7th input; 6 `oDone` pulses; `oSum`=0x40C00000.
- `iClear` during ADD with 2 entries queued and `iValid`=1 carrying 0x40000000 → no `oDone` for the in-flight add; later `oSum`=0x40000000 and `oOverflow`=0.
